// File: rtl/adau_seq_pkg.sv
// Shared types and constants for the ADAU1761 bring-up sequencer.
// ADAU_SEQ_VERIFY_EN adds the read-back states to the state enum.
package adau_seq_pkg;

  localparam int          ADAU_ENTRY_W      = 24;
  localparam logic [15:0] ADAU_DELAY_ADDR   = 16'hFFFF;
  localparam int          ADAU_INIT_DUMMIES = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DELAY,
`ifdef ADAU_SEQ_VERIFY_EN
    S_VERIFY_ISSUE, S_VERIFY_WAIT,
`endif
    S_DONE, S_FAIL
  } seq_state_e;

  // What the single GAP cycle follows, which decides where GAP goes next.
  typedef enum logic [1:0] {GAP_INIT, GAP_WRITE, GAP_READ} gap_kind_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } seq_entry_t;

endpackage

// File: rtl/adau_seq_rom.sv
// Synchronous-read codec register table. Entries past the list (or past
// NUM_ENTRIES) read as zero-length delays, which the sequencer skips over.
module adau_seq_rom
  import adau_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input  logic                    clk,
  input  logic [7:0]              addr,
  output logic [ADAU_ENTRY_W-1:0] entry
);

  localparam seq_entry_t NOP = '{addr: ADAU_DELAY_ADDR, data: 8'h00};

  // Clock control goes first; the delay lets the core clock settle.
  function automatic seq_entry_t lookup(input logic [7:0] a);
    case (a)
      8'd0:    lookup = '{16'h4000, 8'h01};
      8'd1:    lookup = '{16'h4017, 8'h00};
      8'd2:    lookup = '{ADAU_DELAY_ADDR, 8'h02};
      8'd3:    lookup = '{16'h4019, 8'h03};
      8'd4:    lookup = '{16'h400A, 8'h01};
      8'd5:    lookup = '{16'h400C, 8'h01};
      8'd6:    lookup = '{16'h401C, 8'h21};
      8'd7:    lookup = '{16'h401E, 8'h41};
      8'd8:    lookup = '{16'h4029, 8'h03};
      8'd9:    lookup = '{16'h402A, 8'h03};
      8'd10:   lookup = '{16'h40F2, 8'h01};
      8'd11:   lookup = '{16'h40F3, 8'h01};
      8'd12:   lookup = '{16'h40F9, 8'h7F};
      8'd13:   lookup = '{16'h40FA, 8'h03};
      default: lookup = NOP;
    endcase
  endfunction

  always_ff @(posedge clk)
    entry <= (32'(addr) < NUM_ENTRIES) ? lookup(addr) : NOP;

endmodule

// File: rtl/adau1761_config_sequencer.sv
// ADAU1761 bring-up sequencer: SPI-mode init, then one write or delay per
// table entry. ADAU_SEQ_VERIFY_EN adds a read-back check after each write.
module adau1761_config_sequencer
  import adau_seq_pkg::*;
#(
  parameter int NUM_ENTRIES    = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DELAY_UNIT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic        spi_init,
  output logic        spi_write,
  output logic        spi_read,
  output logic [15:0] spi_address,
  output logic [7:0]  spi_wdata,
  input  logic        spi_cs,
  input  logic [39:0] spi_rdata
);

  localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] LAST_IDX   = 8'(NUM_ENTRIES - 1);
  localparam logic [1:0] LAST_DUMMY = 2'(ADAU_INIT_DUMMIES - 1);

  seq_state_e             state;
  gap_kind_e              gap_kind;
  logic [7:0]             idx, fail_idx, rom_addr;
  logic [ADAU_ENTRY_W-1:0] rom_q;
  seq_entry_t             entry;
  logic                   cs_q, cs_rise, tmo_hit;
  logic [1:0]             dummies;
  logic [TMO_W-1:0]       tmo;
  logic [31:0]            dly_cnt;

  assign entry   = seq_entry_t'(rom_q);
  assign cs_rise = spi_cs & ~cs_q;
  assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // The ROM has a registered output, so in the cycle that may advance the
  // index we already address the next entry; FETCH then sees it directly.
  assign rom_addr = ((state == S_GAP && gap_kind != GAP_INIT) || state == S_DELAY)
                    ? idx + 8'd1 : idx;

  adau_seq_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
    .clk   (clk),
    .addr  (rom_addr),
    .entry (rom_q)
  );

`ifdef ADAU_SEQ_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata[39:8];
`else
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      gap_kind    <= GAP_INIT;
      idx         <= '0;
      fail_idx    <= '0;
      cs_q        <= 1'b1;
      dummies     <= '0;
      tmo         <= '0;
      dly_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_index   <= '0;
      spi_init    <= 1'b0;
      spi_write   <= 1'b0;
      spi_read    <= 1'b0;
      spi_address <= '0;
      spi_wdata   <= '0;
    end else begin
      cs_q      <= spi_cs;
      done      <= 1'b0;
      spi_init  <= 1'b0;
      spi_write <= 1'b0;
      spi_read  <= 1'b0;

      case (state)
        S_IDLE:
          if (start) begin
            error <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_INIT;
          end

        S_INIT: begin
          spi_init <= 1'b1;
          tmo      <= '0;
          dummies  <= '0;
          state    <= S_INIT_WAIT;
        end

        // Each dummy transaction gets its own timeout window.
        S_INIT_WAIT:
          if (cs_rise) begin
            tmo <= '0;
            if (dummies == LAST_DUMMY) begin
              gap_kind <= GAP_INIT;
              state    <= S_GAP;
            end else begin
              dummies <= dummies + 2'd1;
            end
          end else if (tmo_hit) begin
            fail_idx <= 8'hFF;
            state    <= S_FAIL;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end

        S_FETCH:
          if (entry.addr == ADAU_DELAY_ADDR) begin
            dly_cnt <= 32'(entry.data) * 32'(DELAY_UNIT);
            state   <= S_DELAY;
          end else begin
            spi_address <= entry.addr;
            spi_wdata   <= entry.data;
            state       <= S_ISSUE;
          end

        S_ISSUE: begin
          spi_write <= 1'b1;
          tmo       <= '0;
          state     <= S_WAIT;
        end

        S_WAIT:
          if (cs_rise) begin
            gap_kind <= GAP_WRITE;
            state    <= S_GAP;
          end else if (tmo_hit) begin
            fail_idx <= idx;
            state    <= S_FAIL;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end

        S_GAP:
          if (gap_kind == GAP_INIT)
            state <= S_FETCH;
`ifdef ADAU_SEQ_VERIFY_EN
          else if (gap_kind == GAP_WRITE)
            state <= S_VERIFY_ISSUE;
          else if (spi_rdata[7:0] != spi_wdata) begin
            fail_idx <= idx;
            state    <= S_FAIL;
          end
`endif
          else if (idx == LAST_IDX)
            state <= S_DONE;
          else begin
            idx   <= idx + 8'd1;
            state <= S_FETCH;
          end

        S_DELAY:
          if (dly_cnt != '0)
            dly_cnt <= dly_cnt - 32'd1;
          else if (idx == LAST_IDX)
            state <= S_DONE;
          else begin
            idx   <= idx + 8'd1;
            state <= S_FETCH;
          end

`ifdef ADAU_SEQ_VERIFY_EN
        S_VERIFY_ISSUE: begin
          spi_read <= 1'b1;
          tmo      <= '0;
          state    <= S_VERIFY_WAIT;
        end

        S_VERIFY_WAIT:
          if (cs_rise) begin
            gap_kind <= GAP_READ;
            state    <= S_GAP;
          end else if (tmo_hit) begin
            fail_idx <= idx;
            state    <= S_FAIL;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
`endif

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_FAIL: begin
          error     <= 1'b1;
          err_index <= fail_idx;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adau1761_config_sequencer.sv
// Directed bench for adau1761_config_sequencer with a simple SPI configurator
// model; honours ADAU_SEQ_VERIFY_EN when the build defines it.
module tb_adau1761_config_sequencer;

  localparam int TXN = 32;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error;
  logic [7:0]  err_index;
  logic        spi_init, spi_write, spi_read;
  logic [15:0] spi_address;
  logic [7:0]  spi_wdata;
  logic        spi_cs;
  logic [39:0] spi_rdata;

  adau1761_config_sequencer #(
    .NUM_ENTRIES(4), .TIMEOUT_CYCLES(64), .DELAY_UNIT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .spi_init(spi_init),
    .spi_write(spi_write), .spi_read(spi_read), .spi_address(spi_address),
    .spi_wdata(spi_wdata), .spi_cs(spi_cs), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

`ifdef ADAU_SEQ_VERIFY_EN
  localparam int RD_PER_RUN = 3;
`else
  localparam int RD_PER_RUN = 0;
`endif

  // Configurator model: cs low for TXN cycles per transaction, init = 3 dummies.
  logic       cs_m, hang, corrupt;
  int         m_cnt, m_left, m_wr;
  logic [7:0] last_wd, rd_byte;

  assign spi_cs    = cs_m;
  assign spi_rdata = {32'h0, rd_byte};

  always @(posedge clk) begin
    if (reset) begin
      cs_m <= 1'b1; m_cnt <= 0; m_left <= 0; m_wr <= 0;
      last_wd <= 8'h00; rd_byte <= 8'h00;
    end else if (spi_init || spi_write || spi_read) begin
      cs_m   <= 1'b0;
      m_cnt  <= TXN;
      m_left <= spi_init ? 3 : 1;
      if (spi_init) m_wr <= 0;
      if (spi_write) begin last_wd <= spi_wdata; m_wr <= m_wr + 1; end
      if (spi_read) rd_byte <= corrupt ? 8'h00 : last_wd;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      if (!(hang && m_wr >= 2)) begin
        cs_m <= 1'b1; m_cnt <= 0; m_left <= m_left - 1;
      end
    end else if (m_left != 0 && cs_m) begin
      cs_m  <= 1'b0;
      m_cnt <= TXN;
    end
  end

  // Monitor, sampled on the falling edge.
  int          cyc, n_init, n_wr, n_rd, n_done, n_rise, n_wide;
  logic        cs_prev;
  logic [2:0]  cmd_prev;
  logic [15:0] wr_addr [64];
  logic [7:0]  wr_data [64];
  int          wr_cyc  [64];

  initial begin
    cyc = 0; n_init = 0; n_wr = 0; n_rd = 0; n_done = 0; n_rise = 0; n_wide = 0;
    cs_prev = 1'b1; cmd_prev = 3'b000;
  end

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    cs_prev  <= spi_cs;
    cmd_prev <= {spi_init, spi_write, spi_read};
    if (({spi_init, spi_write, spi_read} & cmd_prev) != 3'b000) n_wide <= n_wide + 1;
    if (spi_init) n_init <= n_init + 1;
    if (spi_read) n_rd <= n_rd + 1;
    if (done) n_done <= n_done + 1;
    if (spi_cs && !cs_prev) n_rise <= n_rise + 1;
    if (spi_write) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] <= spi_address;
        wr_data[n_wr] <= spi_wdata;
        wr_cyc[n_wr]  <= cyc;
      end
      n_wr <= n_wr + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  // Whole table: writes 0x4000:01, 0x4017:00, delay 2 ticks, 0x4019:03.
  task automatic full_run(input string pfx, input bit extra_start);
    int  b_init, b_wr, b_rd, b_done, b_rise, d0, d1;
    bit  ok;
    b_init = n_init; b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_rise = n_rise;
    pulse_start();
    chk({pfx, "_busy"},     32'(busy), 1);
    chk({pfx, "_err_clr"},  32'(error), 0);
    chk({pfx, "_init_lat1"}, 32'(spi_init), 0);
    @(posedge clk); #1;
    chk({pfx, "_init_lat2"}, 32'(spi_init), 1);
    if (extra_start) begin
      repeat (60) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_idle(3000, ok);
    chk({pfx, "_finish"},   32'(ok), 1);
    chk({pfx, "_done_w_busy"}, 32'(done), 1);
    chk({pfx, "_error"},    32'(error), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({pfx, "_done_1cyc"}, 32'(done), 0);
    chk({pfx, "_n_done"},   32'(n_done - b_done), 1);
    chk({pfx, "_n_init"},   32'(n_init - b_init), 1);
    chk({pfx, "_n_wr"},     32'(n_wr - b_wr), 3);
    chk({pfx, "_n_rd"},     32'(n_rd - b_rd), RD_PER_RUN);
    chk({pfx, "_n_rise"},   32'(n_rise - b_rise), 6 + RD_PER_RUN);
    chk({pfx, "_wa0"}, 32'(wr_addr[b_wr]),     32'h4000);
    chk({pfx, "_wd0"}, 32'(wr_data[b_wr]),     32'h01);
    chk({pfx, "_wa1"}, 32'(wr_addr[b_wr + 1]), 32'h4017);
    chk({pfx, "_wd1"}, 32'(wr_data[b_wr + 1]), 32'h00);
    chk({pfx, "_wa2"}, 32'(wr_addr[b_wr + 2]), 32'h4019);
    chk({pfx, "_wd2"}, 32'(wr_data[b_wr + 2]), 32'h03);
    // Delay entry costs its FETCH plus 2*16+1 DELAY cycles.
    d0 = wr_cyc[b_wr + 1] - wr_cyc[b_wr];
    d1 = wr_cyc[b_wr + 2] - wr_cyc[b_wr + 1];
    chk({pfx, "_dly_extra"}, 32'(d1 - d0), 34);
  endtask

  initial begin
    int  b_init, b_wr, b_rd, b_done;
    bit  ok;
    reset = 1'b1; start = 1'b0; hang = 1'b0; corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_eidx",  32'(err_index), 0);
    chk("rst_init",  32'(spi_init), 0);
    chk("rst_write", 32'(spi_write), 0);
    chk("rst_read",  32'(spi_read), 0);
    chk("rst_addr",  32'(spi_address), 0);
    chk("rst_wdata", 32'(spi_wdata), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    full_run("run1", 1'b1);

    // Configurator stalls on the second write.
    hang = 1'b1;
    b_init = n_init; b_wr = n_wr; b_rd = n_rd; b_done = n_done;
    pulse_start();
    wait_idle(3000, ok);
    chk("tmo_finish", 32'(ok), 1);
    chk("tmo_error",  32'(error), 1);
    chk("tmo_eidx",   32'(err_index), 1);
    chk("tmo_busy",   32'(busy), 0);
    chk("tmo_n_wr",   32'(n_wr - b_wr), 2);
    chk("tmo_n_rd",   32'(n_rd - b_rd), (RD_PER_RUN != 0) ? 1 : 0);
    repeat (100) @(posedge clk);
    #1;
    chk("tmo_quiet_wr",   32'(n_wr - b_wr), 2);
    chk("tmo_quiet_init", 32'(n_init - b_init), 1);
    chk("tmo_n_done",     32'(n_done - b_done), 0);
    chk("tmo_err_sticky", 32'(error), 1);
    hang = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Reset while waiting on the first write.
    b_wr = n_wr;
    pulse_start();
    chk("rstw_err_clr", 32'(error), 0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (n_wr != b_wr) begin ok = 1'b1; break; end
    end
    chk("rstw_first_wr", 32'(ok), 1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstw_busy",  32'(busy), 0);
    chk("rstw_error", 32'(error), 0);
    chk("rstw_eidx",  32'(err_index), 0);
    chk("rstw_addr",  32'(spi_address), 0);
    chk("rstw_wdata", 32'(spi_wdata), 0);
    b_init = n_init; b_wr = n_wr;
    repeat (100) @(posedge clk);
    #1;
    chk("rstw_quiet_wr",   32'(n_wr - b_wr), 0);
    chk("rstw_quiet_init", 32'(n_init - b_init), 0);

    full_run("run2", 1'b0);

`ifdef ADAU_SEQ_VERIFY_EN
    // Read-back returns 0x00 for the 0x01 written to entry 0.
    corrupt = 1'b1;
    b_wr = n_wr; b_rd = n_rd;
    pulse_start();
    wait_idle(3000, ok);
    chk("vfy_finish", 32'(ok), 1);
    chk("vfy_error",  32'(error), 1);
    chk("vfy_eidx",   32'(err_index), 0);
    chk("vfy_n_wr",   32'(n_wr - b_wr), 1);
    chk("vfy_n_rd",   32'(n_rd - b_rd), 1);
    corrupt = 1'b0;
`endif

    chk("pulse_width", 32'(n_wide), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
